decode: RTL and testbench

- Serial receive-side decoder for the FSK link. It sits directly downstream of the frame encoder, after the demodulator has recovered baseband bits.
- It hunts for the 3-bit preamble 1,1,0 and captures the 7-bit Hamming(7,4) payload.
- It computes the syndrome, corrects any single-bit error (including the deliberate noise flip on d1), and presents the 4-bit nibble with a one-cycle valid strobe.
- Input rate is one bit per clk, in the same clock domain as the encoder.

---
 rtl/fsk_frame_pkg.sv | 21 ++
 rtl/hamming74_correct.sv | 42 ++++
 rtl/decode.sv | 92 +++++++++
 tb/tb_decode.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fsk_frame_pkg.sv
// rtl/fsk_frame_pkg.sv - FSK frame constants and FSM states shared by encoder and decoder
package fsk_frame_pkg;

  localparam logic [2:0] PREAMBLE     = 3'b110;
  localparam int         FRAME_BITS   = 10;
  localparam int         PAYLOAD_BITS = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE1 = 2'd1,
    PRE2 = 2'd2,
    DATA = 2'd3
  } state_t;

  // Syndrome {s1,s2,s3} produced by a single flip of each data bit
  localparam logic [2:0] SYN_D3 = 3'b111;
  localparam logic [2:0] SYN_D2 = 3'b110;
  localparam logic [2:0] SYN_D1 = 3'b101;
  localparam logic [2:0] SYN_D0 = 3'b011;

endpackage

// File: rtl/hamming74_correct.sv
// rtl/hamming74_correct.sv - combinational Hamming(7,4) syndrome and single-bit correction
module hamming74_correct
  import fsk_frame_pkg::*;
(
  input  logic [6:0] i_code,
  input  logic       i_correct_en,
  output logic [3:0] o_data,
  output logic [2:0] o_syndrome,
  output logic       o_err
);

  // i_code = {d3,d2,d1,d0,p1,p2,p3}
  logic       w_s1;
  logic       w_s2;
  logic       w_s3;
  logic [2:0] w_syn;
  logic [3:0] w_flip;

  assign w_s1  = i_code[2] ^ i_code[6] ^ i_code[5] ^ i_code[4];
  assign w_s2  = i_code[1] ^ i_code[6] ^ i_code[5] ^ i_code[3];
  assign w_s3  = i_code[0] ^ i_code[6] ^ i_code[4] ^ i_code[3];
  assign w_syn = {w_s1, w_s2, w_s3};

  // Parity-only syndromes fall to default: the data nibble is already right
  always_comb begin
    w_flip = 4'b0000;
    if (i_correct_en) begin
      case (w_syn)
        SYN_D3:  w_flip = 4'b1000;
        SYN_D2:  w_flip = 4'b0100;
        SYN_D1:  w_flip = 4'b0010;
        SYN_D0:  w_flip = 4'b0001;
        default: w_flip = 4'b0000;
      endcase
    end
  end

  assign o_data     = i_code[6:3] ^ w_flip;
  assign o_syndrome = w_syn;
  assign o_err      = |w_syn;

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - serial FSK frame decoder: preamble hunt, Hamming(7,4) capture and correction
module decode
  import fsk_frame_pkg::*;
#(
  parameter logic CORRECT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       err_corrected,
  output logic [2:0] syndrome,
  output logic       busy
);

  localparam logic [2:0] LAST_CNT = 3'(PAYLOAD_BITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_cnt;
  logic [PAYLOAD_BITS-2:0] r_shift;
  logic [3:0]              r_data;
  logic                    r_valid;
  logic                    r_err;
  logic [2:0]              r_syn;

  logic                    w_last;
  logic [6:0]              w_code;
  logic [3:0]              w_data;
  logic [2:0]              w_syn;
  logic                    w_err;

  assign w_last = (r_state == DATA) && (r_cnt == LAST_CNT);
  // p3 is still on the wire at the final edge, so it joins the codeword unregistered
  assign w_code = {r_shift, data_in};

  hamming74_correct u_hamming (
    .i_code       (w_code),
    .i_correct_en (CORRECT_EN),
    .o_data       (w_data),
    .o_syndrome   (w_syn),
    .o_err        (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (data_in == PREAMBLE[2]) w_state_nxt = PRE1;
      PRE1:    w_state_nxt = (data_in == PREAMBLE[1]) ? PRE2 : IDLE;
      PRE2:    if (data_in == PREAMBLE[0]) w_state_nxt = DATA;
      DATA:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_syn   <= '0;
    end else begin
      r_valid <= w_last;
      if (r_state == PRE2) begin
        r_cnt <= '0;
      end else if (r_state == DATA) begin
        r_cnt   <= r_cnt + 3'd1;
        r_shift <= {r_shift[PAYLOAD_BITS-3:0], data_in};
      end
      if (w_last) begin
        r_data <= w_data;
        r_err  <= w_err;
        r_syn  <= w_syn;
      end
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign err_corrected = r_err;
  assign syndrome      = r_syn;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - bench for decode: corrected and raw instances against a frame-level model
module tb_decode;

  logic       clk;
  logic       rst_n;
  logic       data_in;
  logic [3:0] c_data, r_data;
  logic       c_valid, r_valid, c_err, r_err, c_busy, r_busy;
  logic [2:0] c_syn, r_syn;

  decode #(.CORRECT_EN(1'b1)) u_cor (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(c_data), .data_valid(c_valid),
    .err_corrected(c_err), .syndrome(c_syn), .busy(c_busy));

  decode #(.CORRECT_EN(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(r_data), .data_valid(r_valid),
    .err_corrected(r_err), .syndrome(r_syn), .busy(r_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       bz;
    logic       v;
    logic [3:0] d;
    logic [3:0] raw;
    logic [2:0] syn;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] h_d, h_raw;
  logic [2:0] h_syn;
  logic       h_err;
  // Syndrome produced by a flip at codeword position d3,d2,d1,d0,p1,p2,p3
  logic [2:0] syn_of [7] = '{3'b111, 3'b110, 3'b101, 3'b011, 3'b100, 3'b010, 3'b001};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input logic b, input logic bz);
    ent_t e;
    e = '{b: b, bz: bz, v: 1'b0, d: 4'h0, raw: 4'h0, syn: 3'b000};
    q.push_back(e);
  endtask

  // flip: -1 none, 0..6 codeword position; pre: also emit the 1,1,0 preamble
  task automatic push_frame(input logic [3:0] nib, input int flip, input int gap, input bit pre);
    logic cw [7];
    ent_t e;
    cw[0] = nib[3]; cw[1] = nib[2]; cw[2] = nib[1]; cw[3] = nib[0];
    cw[4] = nib[3] ^ nib[2] ^ nib[1];
    cw[5] = nib[3] ^ nib[2] ^ nib[0];
    cw[6] = nib[3] ^ nib[1] ^ nib[0];
    if (flip >= 0) cw[flip] = ~cw[flip];
    if (pre) begin
      push_bit(1'b1, 1'b1); push_bit(1'b1, 1'b1); push_bit(1'b0, 1'b1);
    end
    for (int i = 0; i < 6; i++) push_bit(cw[i], 1'b1);
    e.b = cw[6]; e.bz = 1'b0; e.v = 1'b1; e.d = nib;
    e.raw = {cw[0], cw[1], cw[2], cw[3]};
    e.syn = (flip >= 0) ? syn_of[flip] : 3'b000;
    q.push_back(e);
    for (int i = 0; i < gap; i++) push_bit(1'b0, 1'b0);
  endtask

  task automatic check_all(input logic v, input logic bz);
    chk("valid_cor", {3'b0, c_valid}, {3'b0, v});
    chk("valid_raw", {3'b0, r_valid}, {3'b0, v});
    chk("busy_cor", {3'b0, c_busy}, {3'b0, bz});
    chk("busy_raw", {3'b0, r_busy}, {3'b0, bz});
    chk("data_cor", c_data, h_d);
    chk("data_raw", r_data, h_raw);
    chk("syn_cor", {1'b0, c_syn}, {1'b0, h_syn});
    chk("syn_raw", {1'b0, r_syn}, {1'b0, h_syn});
    chk("err_cor", {3'b0, c_err}, {3'b0, h_err});
    chk("err_raw", {3'b0, r_err}, {3'b0, h_err});
  endtask

  task automatic run_queue();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      data_in = e.b;
      @(posedge clk);
      #1;
      if (e.v) begin
        h_d = e.d; h_raw = e.raw; h_syn = e.syn; h_err = (e.syn != 3'b000);
      end
      check_all(e.v, e.bz);
    end
  endtask

  task automatic clear_hold();
    h_d = 4'h0; h_raw = 4'h0; h_syn = 3'b000; h_err = 1'b0;
  endtask

  initial begin
    clear_hold();
    rst_n   = 1'b0;
    data_in = 1'b1;
    @(posedge clk); #1;
    check_all(1'b0, 1'b0);
    @(posedge clk); #1;
    check_all(1'b0, 1'b0);
    rst_n = 1'b1;

    // Clean 0110 preceded by one idle bit
    push_bit(1'b0, 1'b0);
    push_frame(4'b0110, -1, 1, 1'b1);
    // 1011 with d1 flipped in the channel
    push_frame(4'b1011, 2, 1, 1'b1);
    // 0000 with p2 flipped
    push_frame(4'b0000, 5, 1, 1'b1);
    // Broken preamble 1,0 then a run of 1s before the 0
    push_bit(1'b1, 1'b1); push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b1); push_bit(1'b1, 1'b1); push_bit(1'b1, 1'b1); push_bit(1'b0, 1'b1);
    push_frame(4'b0110, -1, 1, 1'b0);
    // Back-to-back with no gap
    push_frame(4'b0110, -1, 0, 1'b1);
    push_frame(4'b1011, 2, 1, 1'b1);
    run_queue();

    // Reset while the 4th payload bit is on the wire
    push_frame(4'b1010, -1, 0, 1'b1);
    for (int i = 0; i < 3 + 3; i++) begin
      data_in = q[0].b;
      void'(q.pop_front());
      @(posedge clk); #1;
      check_all(1'b0, 1'b1);
    end
    q.delete();
    data_in = 1'b1;
    rst_n   = 1'b0;
    #1;
    clear_hold();
    check_all(1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check_all(1'b0, 1'b0);
    end
    rst_n   = 1'b1;
    data_in = 1'b0;
    push_bit(1'b0, 1'b0); push_bit(1'b0, 1'b0);
    push_frame(4'b1111, -1, 2, 1'b1);
    run_queue();

    // Random frames: any nibble, no error or one flip anywhere, gap 0..2
    for (int f = 0; f < 24; f++) begin
      push_frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)) - 1,
                 int'($urandom_range(0, 2)), 1'b1);
    end
    push_bit(1'b0, 1'b0); push_bit(1'b0, 1'b0);
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
